// File: rtl/harvard_avalon_bus_controller_if.sv
// Avalon memory-mapped bus bundle between the Harvard bus controller (master)
// and the memory-side bus wrapper (slave). All data paths are 32 bits wide.
interface harvard_avalon_bus_controller_if;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    output av_write,
    output av_writedata,
    output av_byteenable,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    input  av_write,
    input  av_writedata,
    input  av_byteenable,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/harvard_avalon_bus_controller.sv
// Serialises a multi-cycle Harvard MIPS core onto one Avalon master port.
// Each instruction runs FETCH -> DECODE -> (DREAD | DWRITE)? -> COMMIT, and
// COMMIT emits a single clk_enable pulse that lets the core advance.
// Every output is registered from the next-state value, so the bus strobes
// line up with the state itself and the asynchronous reset clears them at once.
module harvard_avalon_bus_controller (
  input  logic        clk,
  input  logic        reset,
  output logic        clk_enable,
  output logic        pause,
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  harvard_avalon_bus_controller_if.master av
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_DREAD  = 3'd3,
    ST_DWRITE = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        clk_enable_r;
  logic        pause_r;
  logic [31:0] instr_readdata_r;
  logic [31:0] data_readdata_r;
  logic [31:0] av_address_r;
  logic        av_read_r;
  logic        av_write_r;
  logic [31:0] av_writedata_r;
  logic [3:0]  av_byteenable_r;

  logic [31:0] av_address_next_s;
  logic [31:0] av_writedata_next_s;
  logic        av_read_next_s;
  logic        av_write_next_s;
  logic        instr_capture_s;
  logic        data_capture_s;

  // Byte lanes are always full-word; the low address bits are intentionally dropped.
  logic        unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{instr_address[1:0], data_address[1:0]};

  // Next-state decode: bus states hold while the slave stalls, write beats read.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_read) state_next_s = ST_FETCH;
        else            state_next_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (!av.av_waitrequest) state_next_s = ST_DECODE;
        else                    state_next_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (data_write)     state_next_s = ST_DWRITE;
        else if (data_read) state_next_s = ST_DREAD;
        else                state_next_s = ST_COMMIT;
      end
      ST_DREAD: begin
        if (!av.av_waitrequest) state_next_s = ST_COMMIT;
        else                    state_next_s = ST_DREAD;
      end
      ST_DWRITE: begin
        if (!av.av_waitrequest) state_next_s = ST_COMMIT;
        else                    state_next_s = ST_DWRITE;
      end
      ST_COMMIT: begin
        if (instr_read) state_next_s = ST_FETCH;
        else            state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next bus values: address/data load only on entry to a transfer so they stay
  // frozen across wait states; they return to zero outside transfers.
  always_comb begin
    av_read_next_s      = (state_next_s == ST_FETCH) || (state_next_s == ST_DREAD);
    av_write_next_s     = (state_next_s == ST_DWRITE);
    av_address_next_s   = 32'h0000_0000;
    av_writedata_next_s = 32'h0000_0000;
    if (state_next_s == state_r) begin
      av_address_next_s   = av_address_r;
      av_writedata_next_s = av_writedata_r;
    end else begin
      case (state_next_s)
        ST_FETCH: av_address_next_s = {instr_address[31:2], 2'b00};
        ST_DREAD: av_address_next_s = {data_address[31:2], 2'b00};
        ST_DWRITE: begin
          av_address_next_s   = {data_address[31:2], 2'b00};
          av_writedata_next_s = data_writedata;
        end
        default: begin
          av_address_next_s   = 32'h0000_0000;
          av_writedata_next_s = 32'h0000_0000;
        end
      endcase
    end
    instr_capture_s = (state_r == ST_FETCH) && !av.av_waitrequest;
    data_capture_s  = (state_r == ST_DREAD) && !av.av_waitrequest;
  end

  // State register and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      clk_enable_r     <= 1'b0;
      pause_r          <= 1'b0;
      instr_readdata_r <= 32'h0000_0000;
      data_readdata_r  <= 32'h0000_0000;
      av_address_r     <= 32'h0000_0000;
      av_read_r        <= 1'b0;
      av_write_r       <= 1'b0;
      av_writedata_r   <= 32'h0000_0000;
      av_byteenable_r  <= 4'b0000;
    end else begin
      state_r         <= state_next_s;
      clk_enable_r    <= (state_next_s == ST_COMMIT);
      pause_r         <= (state_next_s == ST_FETCH) || (state_next_s == ST_DECODE) ||
                         (state_next_s == ST_DREAD) || (state_next_s == ST_DWRITE);
      av_address_r    <= av_address_next_s;
      av_read_r       <= av_read_next_s;
      av_write_r      <= av_write_next_s;
      av_writedata_r  <= av_writedata_next_s;
      av_byteenable_r <= (av_read_next_s || av_write_next_s) ? 4'b1111 : 4'b0000;
      if (instr_capture_s) instr_readdata_r <= av.av_readdata;
      else                 instr_readdata_r <= instr_readdata_r;
      if (data_capture_s)  data_readdata_r  <= av.av_readdata;
      else                 data_readdata_r  <= data_readdata_r;
    end
  end

  assign clk_enable       = clk_enable_r;
  assign pause            = pause_r;
  assign instr_readdata   = instr_readdata_r;
  assign data_readdata    = data_readdata_r;
  assign av.av_address    = av_address_r;
  assign av.av_read       = av_read_r;
  assign av.av_write      = av_write_r;
  assign av.av_writedata  = av_writedata_r;
  assign av.av_byteenable = av_byteenable_r;

endmodule

// File: tb/tb_harvard_avalon_bus_controller.sv
// Directed bench for harvard_avalon_bus_controller: reset state, plain and
// memory instructions, wait states, read/write priority, instr_read drop and
// asynchronous reset during a stalled fetch.
module tb_harvard_avalon_bus_controller;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        pause;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int n_vec;
  int n_err;

  harvard_avalon_bus_controller_if av_if ();

  harvard_avalon_bus_controller dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .pause          (pause),
    .instr_read     (instr_read),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .av             (av_if.master)
  );

  // Small read-only memory image answering the Avalon slave side.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'hBFC0_0000: mem_word = 32'h2402_0005;
      32'hBFC0_0004: mem_word = 32'h8C43_1003;
      32'hBFC0_0008: mem_word = 32'hAC45_2004;
      32'hBFC0_000C: mem_word = 32'hAC46_3000;
      32'hBFC0_0010: mem_word = 32'h8C47_4000;
      32'h0000_1000: mem_word = 32'hDEAD_BEEF;
      32'h0000_3000: mem_word = 32'h5555_5555;
      32'h0000_4000: mem_word = 32'h0BAD_F00D;
      default:       mem_word = 32'h0000_0000;
    endcase
  endfunction

  assign av_if.av_readdata = mem_word(av_if.av_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_vec({tag, " clk_enable"}, {31'd0, clk_enable}, 32'd0);
    check_vec({tag, " pause"}, {31'd0, pause}, 32'd0);
    check_vec({tag, " av_read"}, {31'd0, av_if.av_read}, 32'd0);
    check_vec({tag, " av_write"}, {31'd0, av_if.av_write}, 32'd0);
    check_vec({tag, " av_address"}, av_if.av_address, 32'd0);
    check_vec({tag, " av_byteenable"}, {28'd0, av_if.av_byteenable}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    instr_read = 1'b0;
    instr_address = 32'hBFC0_0000;
    data_address = 32'h0;
    data_read = 1'b0;
    data_write = 1'b0;
    data_writedata = 32'h0;
    av_if.av_waitrequest = 1'b0;

    // Reset hold
    step();
    step();
    check_idle_outputs("rst");
    check_vec("rst av_writedata", av_if.av_writedata, 32'd0);
    check_vec("rst instr_readdata", instr_readdata, 32'd0);
    check_vec("rst data_readdata", data_readdata, 32'd0);

    // Plain instruction: FETCH, DECODE, COMMIT
    instr_read = 1'b1;
    reset = 1'b1;
    step();
    check_vec("i0 fetch av_read", {31'd0, av_if.av_read}, 32'd1);
    check_vec("i0 fetch av_address", av_if.av_address, 32'hBFC0_0000);
    check_vec("i0 fetch byteenable", {28'd0, av_if.av_byteenable}, 32'hF);
    check_vec("i0 fetch pause", {31'd0, pause}, 32'd1);
    check_vec("i0 fetch clk_enable", {31'd0, clk_enable}, 32'd0);
    step();
    check_vec("i0 decode av_read", {31'd0, av_if.av_read}, 32'd0);
    check_vec("i0 decode pause", {31'd0, pause}, 32'd1);
    check_vec("i0 instr_readdata", instr_readdata, 32'h2402_0005);
    step();
    check_vec("i0 commit clk_enable", {31'd0, clk_enable}, 32'd1);
    check_vec("i0 commit pause", {31'd0, pause}, 32'd0);

    // Load from unaligned 0x1003
    instr_address = 32'hBFC0_0004;
    data_address = 32'h0000_1003;
    data_read = 1'b1;
    step();
    check_vec("i1 fetch av_address", av_if.av_address, 32'hBFC0_0004);
    check_vec("i1 fetch clk_enable", {31'd0, clk_enable}, 32'd0);
    step();
    check_vec("i1 instr_readdata", instr_readdata, 32'h8C43_1003);
    step();
    check_vec("i1 dread av_read", {31'd0, av_if.av_read}, 32'd1);
    check_vec("i1 dread av_write", {31'd0, av_if.av_write}, 32'd0);
    check_vec("i1 dread av_address", av_if.av_address, 32'h0000_1000);
    check_vec("i1 dread byteenable", {28'd0, av_if.av_byteenable}, 32'hF);
    check_vec("i1 dread pause", {31'd0, pause}, 32'd1);
    step();
    check_vec("i1 commit clk_enable", {31'd0, clk_enable}, 32'd1);
    check_vec("i1 data_readdata", data_readdata, 32'hDEAD_BEEF);

    // Store with three wait states
    instr_address = 32'hBFC0_0008;
    data_read = 1'b0;
    data_write = 1'b1;
    data_address = 32'h0000_2004;
    data_writedata = 32'hCAFE_F00D;
    step();
    step();
    check_vec("i2 instr_readdata", instr_readdata, 32'hAC45_2004);
    av_if.av_waitrequest = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) av_if.av_waitrequest = 1'b0;
      check_vec($sformatf("i2 c%0d av_write", c), {31'd0, av_if.av_write}, 32'd1);
      check_vec($sformatf("i2 c%0d av_read", c), {31'd0, av_if.av_read}, 32'd0);
      check_vec($sformatf("i2 c%0d av_address", c), av_if.av_address, 32'h0000_2004);
      check_vec($sformatf("i2 c%0d av_writedata", c), av_if.av_writedata, 32'hCAFE_F00D);
      check_vec($sformatf("i2 c%0d clk_enable", c), {31'd0, clk_enable}, 32'd0);
      step();
    end
    check_vec("i2 commit clk_enable", {31'd0, clk_enable}, 32'd1);
    check_vec("i2 commit av_write", {31'd0, av_if.av_write}, 32'd0);

    // Read and write both asserted: write wins
    instr_address = 32'hBFC0_000C;
    data_read = 1'b1;
    data_write = 1'b1;
    data_address = 32'h0000_3000;
    data_writedata = 32'h1234_5678;
    step();
    step();
    step();
    check_vec("i3 av_write", {31'd0, av_if.av_write}, 32'd1);
    check_vec("i3 av_read", {31'd0, av_if.av_read}, 32'd0);
    check_vec("i3 av_writedata", av_if.av_writedata, 32'h1234_5678);
    step();
    check_vec("i3 commit clk_enable", {31'd0, clk_enable}, 32'd1);
    check_vec("i3 data_readdata kept", data_readdata, 32'hDEAD_BEEF);

    // Drop instr_read during DREAD
    instr_address = 32'hBFC0_0010;
    data_write = 1'b0;
    data_read = 1'b1;
    data_address = 32'h0000_4000;
    step();
    step();
    step();
    check_vec("i4 dread av_read", {31'd0, av_if.av_read}, 32'd1);
    instr_read = 1'b0;
    step();
    check_vec("i4 commit clk_enable", {31'd0, clk_enable}, 32'd1);
    check_vec("i4 data_readdata", data_readdata, 32'h0BAD_F00D);
    step();
    check_idle_outputs("i4 idle1");
    step();
    check_idle_outputs("i4 idle2");

    // Asynchronous reset during a stalled fetch
    instr_read = 1'b1;
    instr_address = 32'hBFC0_0014;
    av_if.av_waitrequest = 1'b1;
    step();
    check_vec("i5 fetch av_read", {31'd0, av_if.av_read}, 32'd1);
    step();
    check_vec("i5 stall av_read", {31'd0, av_if.av_read}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("i5 async");
    check_vec("i5 async instr_readdata", instr_readdata, 32'd0);
    check_vec("i5 async data_readdata", data_readdata, 32'd0);
    av_if.av_waitrequest = 1'b0;
    step();
    check_idle_outputs("i5 held");
    step();
    check_vec("i5 held2 clk_enable", {31'd0, clk_enable}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
